// File: rtl/xram_wbuf_ctrl.sv
// xram_wbuf_ctrl: XRAM-side slave for the AES accelerator's external-memory port.
// Writes are posted into a small FIFO and acked in one cycle. Buffered writes drain
// to a single-port byte-wide SRAM in the background. Reads wait for an empty buffer,
// so a read always observes every write posted before it, and complete with a fixed
// SRAM latency.
module xram_wbuf_ctrl #(
    parameter int WBUF_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   xram_addr,
    input  logic [7:0]                    xram_data_out,
    input  logic                          xram_stb,
    input  logic                          xram_wr,
    output logic                          xram_ack,
    output logic [7:0]                    xram_data_in,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [15:0]                   mem_addr,
    output logic [7:0]                    mem_wdata,
    input  logic [7:0]                    mem_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
    output logic                          busy
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = 3;

    localparam logic [CW-1:0] DEPTH_C   = CW'(WBUF_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [LW-1:0] LAT_LOAD  = LW'(RD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_RESP = 2'd2
    } rd_state_t;

    rd_state_t       state_r;
    logic [LW-1:0]   lat_cnt_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [15:0]     fifo_addr_r [WBUF_DEPTH];
    logic [7:0]      fifo_data_r [WBUF_DEPTH];

    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            drain_now_s;
    logic            push_s;
    logic            pop_s;
    logic            rd_accept_s;
    logic [CW-1:0]   count_next_s;

    // Request qualification, drain scheduling and next FIFO occupancy.
    always_comb begin
        fifo_full_s  = (wbuf_count == DEPTH_C);
        fifo_empty_s = (wbuf_count == CNT_ZERO);
        // A drain write currently on the SRAM port; a read must not be issued behind it.
        drain_now_s  = mem_en & mem_we;
        // Writes are posted regardless of read FSM state; only a full buffer stalls them.
        push_s       = xram_stb & xram_wr & ~xram_ack & ~fifo_full_s;
        // Draining only while the read FSM is idle keeps the SRAM port single-owner.
        pop_s        = ~fifo_empty_s & (state_r == ST_IDLE);
        rd_accept_s  = xram_stb & ~xram_wr & ~xram_ack & (state_r == ST_IDLE)
                       & fifo_empty_s & ~drain_now_s;
        count_next_s = wbuf_count;
        if (push_s && !pop_s) begin
            count_next_s = wbuf_count + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = wbuf_count - CNT_ONE;
        end else begin
            count_next_s = wbuf_count;
        end
    end

    // FIFO storage; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= xram_addr;
            fifo_data_r[wr_ptr_r] <= xram_data_out;
        end
    end

    // Pointers, SRAM port, ack/data response, occupancy, busy and the read FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            lat_cnt_r    <= {LW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            wbuf_count   <= CNT_ZERO;
            xram_ack     <= 1'b0;
            xram_data_in <= 8'h00;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 8'h00;
            busy         <= 1'b0;
        end else begin
            xram_ack   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            wbuf_count <= count_next_s;

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                xram_ack <= 1'b1;
            end

            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= fifo_addr_r[rd_ptr_r];
                mem_wdata <= fifo_data_r[rd_ptr_r];
            end else if (rd_accept_s) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= xram_addr;
            end

            case (state_r)
                ST_IDLE: begin
                    if (rd_accept_s) begin
                        state_r   <= ST_RD_WAIT;
                        lat_cnt_r <= LAT_LOAD;
                        busy      <= 1'b1;
                    end else begin
                        busy <= (count_next_s != CNT_ZERO);
                    end
                end
                ST_RD_WAIT: begin
                    busy <= 1'b1;
                    // Counter reaches zero exactly in the cycle mem_rdata is valid.
                    if (lat_cnt_r == {LW{1'b0}}) begin
                        xram_ack     <= 1'b1;
                        xram_data_in <= mem_rdata;
                        state_r      <= ST_RD_RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                ST_RD_RESP: begin
                    state_r <= ST_IDLE;
                    busy    <= (count_next_s != CNT_ZERO);
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= (count_next_s != CNT_ZERO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xram_wbuf_ctrl.sv
// Directed testbench for xram_wbuf_ctrl with a behavioural SRAM model.
// Inputs change 1 time unit after each rising edge; outputs are checked at that point.
module tb_xram_wbuf_ctrl;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 7;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   xram_addr;
    logic [7:0]    xram_data_out;
    logic          xram_stb;
    logic          xram_wr;
    logic          xram_ack;
    logic [7:0]    xram_data_in;
    logic          mem_en;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [CW-1:0] wbuf_count;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    xram_wbuf_ctrl #(.WBUF_DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .xram_addr(xram_addr), .xram_data_out(xram_data_out),
        .xram_stb(xram_stb), .xram_wr(xram_wr),
        .xram_ack(xram_ack), .xram_data_in(xram_data_in),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wbuf_count(wbuf_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM model: 256 bytes indexed by addr[7:0]; unwritten bytes read as addr[7:0]^0x7C.
    logic [7:0]   sram [256];
    logic [255:0] sram_vld = '0;
    logic [7:0]   rd_pipe [RD_LAT] = '{default: 8'h00};
    logic [23:0]  wr_log [$];

    function automatic logic [7:0] bg(input logic [15:0] a);
        return a[7:0] ^ 8'h7C;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            sram[mem_addr[7:0]]     <= mem_wdata;
            sram_vld[mem_addr[7:0]] <= 1'b1;
            wr_log.push_back({mem_addr, mem_wdata});
        end
        rd_pipe[0] <= (mem_en && !mem_we) ?
                      (sram_vld[mem_addr[7:0]] ? sram[mem_addr[7:0]] : bg(mem_addr)) : 8'h00;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; xram_stb = 1'b0; xram_wr = 1'b0; xram_addr = 16'h0000; xram_data_out = 8'h00;
        tick(); tick();
        checks++;
        if ({xram_ack, xram_data_in, mem_en, mem_we, mem_addr, mem_wdata, wbuf_count, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b din=%h en=%b we=%b addr=%h wd=%h cnt=%0d busy=%b want all 0",
                     xram_ack, xram_data_in, mem_en, mem_we, mem_addr, mem_wdata, wbuf_count, busy);
        end
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({xram_ack, mem_en, wbuf_count, busy} !== '0) begin
            failures++;
            $display("FAIL reset_release_idle: got ack=%b en=%b cnt=%0d busy=%b want 0", xram_ack, mem_en, wbuf_count, busy);
        end
    endtask

    task automatic test_single_write();
        int base = wr_log.size();
        xram_stb = 1'b1; xram_wr = 1'b1; xram_addr = 16'h1234; xram_data_out = 8'hA5;
        tick();
        checks++;
        if ({xram_ack, wbuf_count, busy, mem_en} !== {1'b1, CW'(1), 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_ack: got ack=%b cnt=%0d busy=%b en=%b want 1 1 1 0", xram_ack, wbuf_count, busy, mem_en);
        end
        xram_stb = 1'b0; xram_wr = 1'b0;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h1234, 8'hA5}) begin
            failures++;
            $display("FAIL single_mem: got en=%b we=%b addr=%h wd=%h want 1 1 1234 a5", mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({xram_ack, wbuf_count, busy} !== {1'b0, CW'(0), 1'b0}) begin
            failures++;
            $display("FAIL single_drained: got ack=%b cnt=%0d busy=%b want 0 0 0", xram_ack, wbuf_count, busy);
        end
        tick();
        checks++;
        if (mem_en !== 1'b0 || wr_log.size() != base + 1) begin
            failures++;
            $display("FAIL single_once: got en=%b writes=%0d want 0 %0d", mem_en, wr_log.size() - base, 1);
        end
    endtask

    task automatic test_read_latency();
        xram_stb = 1'b1; xram_wr = 1'b0; xram_addr = 16'h0040;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, busy, xram_ack} !== {1'b1, 1'b0, 16'h0040, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rd_issue: got en=%b we=%b addr=%h busy=%b ack=%b want 1 0 0040 1 0", mem_en, mem_we, mem_addr, busy, xram_ack);
        end
        for (int k = 0; k < RD_LAT; k++) begin
            tick();
            checks++;
            if (xram_ack !== 1'b0) begin
                failures++;
                $display("FAIL rd_early_ack: got ack=%b at wait cycle %0d want 0", xram_ack, k);
            end
        end
        tick();
        checks++;
        if ({xram_ack, xram_data_in} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL rd_ack: got ack=%b data=%h want 1 3c", xram_ack, xram_data_in);
        end
        tick();
        checks++;
        if ({xram_ack, mem_en, xram_data_in, busy} !== {1'b0, 1'b0, 8'h3C, 1'b0}) begin
            failures++;
            $display("FAIL rd_after_ack: got ack=%b en=%b data=%h busy=%b want 0 0 3c 0", xram_ack, mem_en, xram_data_in, busy);
        end
        xram_stb = 1'b0;
    endtask

    task automatic test_held_strobe();
        int base = wr_log.size();
        xram_stb = 1'b1; xram_wr = 1'b1; xram_addr = 16'h0100; xram_data_out = 8'h42;
        tick();
        checks++;
        if ({xram_ack, wbuf_count} !== {1'b1, CW'(1)}) begin
            failures++;
            $display("FAIL held_ack: got ack=%b cnt=%0d want 1 1", xram_ack, wbuf_count);
        end
        tick();
        checks++;
        if ({xram_ack, wbuf_count, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b0, CW'(0), 1'b1, 1'b1, 16'h0100, 8'h42}) begin
            failures++;
            $display("FAIL held_single_push: got ack=%b cnt=%0d en=%b we=%b addr=%h wd=%h want 0 0 1 1 0100 42",
                     xram_ack, wbuf_count, mem_en, mem_we, mem_addr, mem_wdata);
        end
        xram_stb = 1'b0; xram_wr = 1'b0;
        tick(); tick();
        checks++;
        if (wbuf_count !== CW'(0) || wr_log.size() != base + 1) begin
            failures++;
            $display("FAIL held_write_count: got cnt=%0d writes=%0d want 0 1", wbuf_count, wr_log.size() - base);
        end
    endtask

    task automatic test_raw();
        xram_stb = 1'b1; xram_wr = 1'b1; xram_addr = 16'h0040; xram_data_out = 8'h77;
        tick();
        checks++;
        if (xram_ack !== 1'b1) begin
            failures++;
            $display("FAIL raw_wr_ack: got ack=%b want 1", xram_ack);
        end
        xram_wr = 1'b0;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, xram_ack} !== {1'b1, 1'b1, 16'h0040, 8'h77, 1'b0}) begin
            failures++;
            $display("FAIL raw_drain: got en=%b we=%b addr=%h wd=%h ack=%b want 1 1 0040 77 0",
                     mem_en, mem_we, mem_addr, mem_wdata, xram_ack);
        end
        tick();
        checks++;
        if (mem_en !== 1'b0) begin
            failures++;
            $display("FAIL raw_read_held_off: got en=%b want 0", mem_en);
        end
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            failures++;
            $display("FAIL raw_read_issue: got en=%b we=%b addr=%h want 1 0 0040", mem_en, mem_we, mem_addr);
        end
        for (int k = 0; k < RD_LAT; k++) begin
            tick();
            checks++;
            if (xram_ack !== 1'b0) begin
                failures++;
                $display("FAIL raw_early_ack: got ack=%b at wait cycle %0d want 0", xram_ack, k);
            end
        end
        tick();
        checks++;
        if ({xram_ack, xram_data_in} !== {1'b1, 8'h77}) begin
            failures++;
            $display("FAIL raw_data: got ack=%b data=%h want 1 77", xram_ack, xram_data_in);
        end
        xram_stb = 1'b0;
        tick();
    endtask

    task automatic test_burst_full();
        // Cycle k after the read accept: input write index (-1 idle), expected ack and count.
        int in_sel  [15] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 4, -1, -1, -1, -1};
        int exp_ack [15] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        int exp_cnt [15] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 3, 3, 2, 1, 0};
        int base = wr_log.size();
        xram_stb = 1'b1; xram_wr = 1'b0; xram_addr = 16'h0050;
        tick();
        checks++;
        if ({mem_en, mem_we} !== 2'b10) begin
            failures++;
            $display("FAIL burst_rd_issue: got en=%b we=%b want 1 0", mem_en, mem_we);
        end
        for (int k = 1; k <= 15; k++) begin
            checks++;
            if (xram_ack !== exp_ack[k-1][0] || wbuf_count !== CW'(exp_cnt[k-1])) begin
                failures++;
                $display("FAIL burst_cycle%0d: got ack=%b cnt=%0d want %0d %0d", k, xram_ack, wbuf_count, exp_ack[k-1], exp_cnt[k-1]);
            end
            if (k == 9) begin
                checks++;
                if (xram_data_in !== 8'h2C) begin
                    failures++;
                    $display("FAIL burst_rd_data: got %h want 2c", xram_data_in);
                end
            end
            if (in_sel[k-1] >= 0) begin
                xram_stb = 1'b1; xram_wr = 1'b1;
                xram_addr = 16'(in_sel[k-1]); xram_data_out = 8'h10 + 8'(in_sel[k-1]);
            end else begin
                xram_stb = 1'b0; xram_wr = 1'b0;
            end
            tick();
        end
        checks++;
        if (wr_log.size() != base + 5) begin
            failures++;
            $display("FAIL burst_write_count: got %0d want 5", wr_log.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_log[base + i] !== {16'(i), 8'h10 + 8'(i)}) begin
                    failures++;
                    $display("FAIL burst_order%0d: got %h want %h", i, wr_log[base + i], {16'(i), 8'h10 + 8'(i)});
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int base = wr_log.size();
        xram_stb = 1'b1; xram_wr = 1'b0; xram_addr = 16'h0060;
        tick();
        xram_wr = 1'b1; xram_addr = 16'h0070; xram_data_out = 8'hAA;
        tick();
        xram_addr = 16'h0071; xram_data_out = 8'hBB;
        tick();
        tick();
        checks++;
        if ({xram_ack, wbuf_count, busy} !== {1'b1, CW'(2), 1'b1}) begin
            failures++;
            $display("FAIL rstmid_setup: got ack=%b cnt=%0d busy=%b want 1 2 1", xram_ack, wbuf_count, busy);
        end
        xram_stb = 1'b0; xram_wr = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if ({xram_ack, xram_data_in, mem_en, mem_we, mem_addr, mem_wdata, wbuf_count, busy} !== '0) begin
            failures++;
            $display("FAIL rstmid_async: got ack=%b din=%h en=%b we=%b addr=%h wd=%h cnt=%0d busy=%b want all 0",
                     xram_ack, xram_data_in, mem_en, mem_we, mem_addr, mem_wdata, wbuf_count, busy);
        end
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < RD_LAT + 4; k++) begin
            tick();
            checks++;
            if ({xram_ack, mem_en, wbuf_count} !== '0) begin
                failures++;
                $display("FAIL rstmid_quiet: got ack=%b en=%b cnt=%0d at cycle %0d want 0 0 0", xram_ack, mem_en, wbuf_count, k);
            end
        end
        checks++;
        if (wr_log.size() != base) begin
            failures++;
            $display("FAIL rstmid_discard: got %0d writes want 0", wr_log.size() - base);
        end
        xram_stb = 1'b1; xram_wr = 1'b0; xram_addr = 16'h0070;
        tick();
        for (int k = 0; k < RD_LAT; k++) tick();
        tick();
        checks++;
        if ({xram_ack, xram_data_in} !== {1'b1, 8'h0C}) begin
            failures++;
            $display("FAIL rstmid_read: got ack=%b data=%h want 1 0c", xram_ack, xram_data_in);
        end
        xram_stb = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_latency();
        test_held_strobe();
        test_raw();
        test_burst_full();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
